// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
//   Encodings shared between the instruction cache, mem_ctrl and the IF stage:
//   mem_ctrl request codes, port-select codes, transfer length and the cache
//   controller state type.
// -----------------------------------------------------------------------------
package icache_pkg;

    // rw_IF_in encodings seen by mem_ctrl
    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;

    // IF_or_MEM: which requester mem_ctrl is currently serving
    localparam logic [1:0] SEL_IF   = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;

    // data_length_IF for a 32-bit read (includes mem latency slot)
    localparam logic [2:0] LEN_WORD = 3'd4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/icache_if.sv
// -----------------------------------------------------------------------------
// icache_if
//   Bundles the fetch handshake (IF stage <-> cache) and the cache's port into
//   mem_ctrl.
//   slave  : the cache's view (takes fetches, drives mem_ctrl requests)
//   master : the environment's view (IF stage + mem_ctrl)
// -----------------------------------------------------------------------------
interface icache_if #(
    parameter int ADDR_WIDTH = 32
);
    // IF stage side
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  req_ready;
    logic                  if_flush;
    logic                  inst_valid;
    logic [31:0]           inst;
    logic [ADDR_WIDTH-1:0] inst_pc;

    // mem_ctrl side
    logic [1:0]            rw_IF_out;
    logic [ADDR_WIDTH-1:0] addr_to_ctrl;
    logic [2:0]            len_to_ctrl;
    logic                  ctrl_busy;
    logic [1:0]            ctrl_sel;
    logic [31:0]           ctrl_data;
    logic [ADDR_WIDTH-1:0] ctrl_pc_back;

    modport slave (
        input  req_valid, req_pc, if_flush,
        input  ctrl_busy, ctrl_sel, ctrl_data, ctrl_pc_back,
        output req_ready, inst_valid, inst, inst_pc,
        output rw_IF_out, addr_to_ctrl, len_to_ctrl
    );

    modport master (
        output req_valid, req_pc, if_flush,
        output ctrl_busy, ctrl_sel, ctrl_data, ctrl_pc_back,
        input  req_ready, inst_valid, inst, inst_pc,
        input  rw_IF_out, addr_to_ctrl, len_to_ctrl
    );

endinterface

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
//   Direct-mapped line storage: one valid bit, one tag and one 32-bit word per
//   line. Combinational read port, synchronous write port, valid bits cleared
//   synchronously on rst.
//   clk, rst      : clock, synchronous active-high reset
//   i_rd_index    : read line index
//   o_rd_valid/o_rd_tag/o_rd_data : contents of the addressed line
//   i_wr_en, i_wr_index, i_wr_tag, i_wr_data : line fill port
// -----------------------------------------------------------------------------
module icache_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic [31:0]           o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [31:0]           i_wr_data
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [31:0]         r_data [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays are intentionally not reset; clearing the valid
    // bits already makes stale contents unreachable, and it keeps the storage
    // mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
//   Direct-mapped instruction cache between the IF stage and mem_ctrl's IF
//   port. Hits return the word on the next edge; misses issue one 4-byte read
//   to mem_ctrl, fill the line and return the word.
//   clk  : single clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : icache_if.slave - fetch handshake plus the mem_ctrl IF port
// -----------------------------------------------------------------------------
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic    clk,
    input  logic    rst,
    icache_if.slave bus
);
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_rw, w_rw_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [2:0]            r_len, w_len_nxt;
    logic [ADDR_WIDTH-1:0] r_pend_pc, w_pend_nxt;
    logic                  r_drop, w_drop_nxt;
    logic                  r_inst_valid, w_inst_valid_nxt;
    logic [31:0]           r_inst, w_inst_nxt;
    logic [ADDR_WIDTH-1:0] r_inst_pc, w_inst_pc_nxt;
    logic                  r_prev_busy;

    logic                  w_rd_valid;
    logic [TAG_BITS-1:0]   w_rd_tag;
    logic [31:0]           w_rd_data;
    logic                  w_wr_en;
    logic                  w_accept, w_hit, w_grant, w_complete, w_pc_match;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_index (bus.req_pc[INDEX_BITS+1:2]),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (r_pend_pc[INDEX_BITS+1:2]),
        .i_wr_tag   (r_pend_pc[ADDR_WIDTH-1:INDEX_BITS+2]),
        .i_wr_data  (bus.ctrl_data)
    );

    assign bus.req_ready = (r_state == IDLE) && !bus.if_flush && !rst;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_hit         = w_rd_valid && (w_rd_tag == bus.req_pc[ADDR_WIDTH-1:INDEX_BITS+2]);
    assign w_grant       = bus.ctrl_busy && (bus.ctrl_sel == SEL_IF);
    // mem_ctrl signals completion by dropping busy while still pointed at IF.
    assign w_complete    = r_prev_busy && !bus.ctrl_busy && (bus.ctrl_sel == SEL_IF);
    assign w_pc_match    = (bus.ctrl_pc_back == r_pend_pc);

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_rw_nxt         = r_rw;
        w_addr_nxt       = r_addr;
        w_len_nxt        = r_len;
        w_pend_nxt       = r_pend_pc;
        w_drop_nxt       = r_drop;
        w_inst_valid_nxt = 1'b0;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_wr_en          = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_hit) begin
                        w_inst_valid_nxt = 1'b1;
                        w_inst_nxt       = w_rd_data;
                        w_inst_pc_nxt    = bus.req_pc;
                    end else begin
                        w_pend_nxt  = bus.req_pc;
                        w_rw_nxt    = RW_READ;
                        w_addr_nxt  = bus.req_pc;
                        w_len_nxt   = LEN_WORD;
                        w_state_nxt = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                // A grant means the access is already under way, so a flush in
                // the same cycle only marks the response for dropping.
                if (w_grant) begin
                    w_rw_nxt    = RW_IDLE;
                    w_drop_nxt  = bus.if_flush;
                    w_state_nxt = MISS_WAIT;
                end else if (bus.if_flush) begin
                    w_rw_nxt    = RW_IDLE;
                    w_state_nxt = IDLE;
                end
            end
            MISS_WAIT: begin
                if (w_complete) begin
                    w_wr_en = w_pc_match;
                    if (!r_drop) begin
                        w_inst_valid_nxt = 1'b1;
                        w_inst_nxt       = bus.ctrl_data;
                        w_inst_pc_nxt    = r_pend_pc;
                    end
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (bus.if_flush) begin
                    w_drop_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (bus.if_flush) w_inst_valid_nxt = 1'b0;
        if (rst)          w_wr_en          = 1'b0;
    end

    // NOTE: non-blocking assignments throughout so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rw         <= RW_IDLE;
            r_addr       <= '0;
            r_len        <= '0;
            r_pend_pc    <= '0;
            r_drop       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_prev_busy  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rw         <= w_rw_nxt;
            r_addr       <= w_addr_nxt;
            r_len        <= w_len_nxt;
            r_pend_pc    <= w_pend_nxt;
            r_drop       <= w_drop_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_prev_busy  <= bus.ctrl_busy;
        end
    end

    assign bus.rw_IF_out    = r_rw;
    assign bus.addr_to_ctrl = r_addr;
    assign bus.len_to_ctrl  = r_len;
    assign bus.inst_valid   = r_inst_valid;
    assign bus.inst         = r_inst;
    assign bus.inst_pc      = r_inst_pc;

    // A fill returning a different pc than the outstanding miss is a mem_ctrl
    // protocol error; the line is left unwritten in that case.
    a_pc_back_matches: assert property (@(posedge clk) disable iff (rst)
        (r_state == MISS_WAIT && w_complete) |-> w_pc_match);

endmodule
